des_mmio_engine: RTL and testbench
==================================

Name: des_mmio_engine

Overview:
- Memory-mapped responder for the MIPS M-stage data bus: accepts CPU stores of DES key/data words and CPU loads of status and result.
- Replaces the free-running combinational DES path with a sequenced 16-round iterative engine: one round per clock, with a start/busy/done handshake visible to software.
- Drives an external combinational single-round unit (des_round: IP/FP, key schedule and f-function live there). This block owns all registers, sequencing and bus decode.

Parameters:
- ROUNDS, 16, number of round iterations per operation (4-bit round index; legal range 1-16).
- BASE, 32'h00000080, byte base address of the 8-word register window (aligned to 32 bytes).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous, active-low reset
- memwrite  in  1  store strobe from M stage
- addr  in  32  M-stage byte address (aluout)
- wdata  in  32  M-stage store data (writedata)
- rdata  out  32  load data; combinational from registers and addr
- hit  out  1  addr falls in [BASE, BASE+0x1F]; steers the external read mux
- rnd_state  out  64  current L||R state to des_round
- rnd_key  out  64  {UK,LK} latched key
- rnd_idx  out  4  current round index 0..ROUNDS-1
- rnd_enc  out  1  1=encrypt, 0=decrypt (latched at start)
- rnd_next  in  64  des_round result for this cycle
- busy  out  1  engine running
- done  out  1  result valid (sticky)

Behaviour:
- Register map (offset from BASE, word-aligned; addr[1:0] ignored):
  - 0x00 UK (R/W)
  - 0x04 LK (R/W)
  - 0x08 UD (R/W)
  - 0x0C LD (R/W)
  - 0x10 CTRL: write bit0=start, bit1=enc; read returns {30'b0, enc_latched, 1'b0}
  - 0x14 STATUS (RO): {30'b0, done, busy}
  - 0x18 OUT_HI (RO)
  - 0x1C OUT_LO (RO)
  - Writes to RO offsets are ignored.
- Writes take effect on the rising clk edge when memwrite=1 and hit=1.
- Reads are combinational, with no added latency, so a lw in M sees the current register value.
- Reset (async, reset_n=0): UK, LK, UD, LD, OUT_HI, OUT_LO, state and enc_latched = 0; round counter = 0; FSM = IDLE; busy=0; done=0.
- FSM:
  - IDLE: busy=0. A CTRL write with bit0=1 loads state<={UD,LD}, enc_latched<=bit1, counter<=0, done<=0, then goes to RUN.
  - RUN: busy=1; rnd_idx=counter. Each cycle state<=rnd_next and counter++. On the cycle counter==ROUNDS-1: OUT_HI/OUT_LO<=rnd_next, done<=1, go to IDLE.
  - Latency: start store at edge N; busy high for exactly ROUNDS cycles; done=1 and OUT valid after edge N+ROUNDS.
- While busy:
  - Writes to UK/LK/UD/LD are ignored. The key and operand stay stable for the whole operation.
  - A start write is ignored; the operation in progress is not restarted.
  - Loads remain legal: OUT_HI/OUT_LO hold the previous result until the new result commits.
- done stays set until the next accepted start. A reset mid-RUN aborts the operation with outputs at reset values.
- A store in the same cycle as round completion is accepted only if it targets an accepted address in IDLE semantics on the next edge. Within the completion cycle itself the block is still busy, so key/data stores are dropped.
- When hit=0, rdata=0; no state changes.
- rnd_key is always {UK,LK}; rnd_state is always the state register.

Test Plan:
- Reset with reset_n=0 mid-RUN (cycle 7) -> busy=0, done=0, STATUS read=0, OUT_HI/LO=0 immediately (async).
- Stub des_round (rnd_next=rnd_state+1), UD=0, LD=5, start enc -> busy=1 for exactly 16 cycles, then done=1, OUT_HI=0, OUT_LO=0x15, CTRL read=0x2.
- Real des_round, key 133457799BBCDFF1, data 0123456789ABCDEF, enc -> OUT_HI=85E81354, OUT_LO=0F0AB405. Then decrypt that result -> 01234567/89ABCDEF.
- During RUN: store UD=FFFFFFFF and a second start -> result is unchanged from the case above; UD reads the old value; exactly one 16-cycle busy window.
- Address decode:
  - sw to BASE+0x20 -> no register change, hit=0, rdata=0.
  - sw to BASE+0x18 -> OUT_HI unchanged.
  - lw of BASE+0x16 returns STATUS (addr[1:0] ignored).
- Back-to-back: start issued on the first IDLE cycle after done -> done clears that edge, and the new result appears 16 cycles later.

Source files
------------

// File: rtl/des_mmio_engine.sv
// ============================================================================
// Module   : des_mmio_engine
// Purpose  : Memory-mapped iterative DES sequencer; one external round per clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_mmio_engine #(
    parameter int          ROUNDS = 16,
    parameter logic [31:0] BASE   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [63:0] rnd_state,
    output logic [63:0] rnd_key,
    output logic [3:0]  rnd_idx,
    output logic        rnd_enc,
    input  logic [63:0] rnd_next,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;
    localparam logic [3:0] c_last = 4'(ROUNDS - 1);

    logic [0:0]  r_fsm;
    logic [0:0]  w_fsm_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_uk, r_lk, r_ud, r_ld, r_out_hi, r_out_lo;
    logic [63:0] r_state;
    logic        r_enc;
    logic        r_done;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_start;
    logic        w_last;
    logic        w_unused_bits;

    // Byte lanes are not decoded; every access is treated as a full word.
    assign w_unused_bits = ^addr[1:0];
    assign w_off         = addr[4:2];
    assign hit           = (addr[31:5] == BASE[31:5]);
    assign w_wr          = memwrite && hit && (r_fsm == c_idle);
    assign w_start       = w_wr && (w_off == 3'd4) && wdata[0];
    assign w_last        = (r_fsm == c_run) && (r_cnt == c_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= c_idle;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_idle:  if (w_start) w_fsm_next = c_run;
            c_run:   if (w_last)  w_fsm_next = c_idle;
            default: w_fsm_next = c_idle;
        endcase
    end

    always_comb begin
        busy = (r_fsm == c_run);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_uk     <= '0;
            r_lk     <= '0;
            r_ud     <= '0;
            r_ld     <= '0;
            r_out_hi <= '0;
            r_out_lo <= '0;
            r_state  <= '0;
            r_enc    <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else if (r_fsm == c_run) begin
            r_state <= rnd_next;
            r_cnt   <= r_cnt + 4'd1;
            if (w_last) begin
                r_out_hi <= rnd_next[63:32];
                r_out_lo <= rnd_next[31:0];
                r_done   <= 1'b1;
            end
        end else if (w_wr) begin
            case (w_off)
                3'd0: r_uk <= wdata;
                3'd1: r_lk <= wdata;
                3'd2: r_ud <= wdata;
                3'd3: r_ld <= wdata;
                3'd4: begin
                    if (wdata[0]) begin
                        r_state <= {r_ud, r_ld};
                        r_enc   <= wdata[1];
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (w_off)
                3'd0:    rdata = r_uk;
                3'd1:    rdata = r_lk;
                3'd2:    rdata = r_ud;
                3'd3:    rdata = r_ld;
                3'd4:    rdata = {30'b0, r_enc, 1'b0};
                3'd5:    rdata = {30'b0, r_done, busy};
                3'd6:    rdata = r_out_hi;
                default: rdata = r_out_lo;
            endcase
        end
    end

    assign done      = r_done;
    assign rnd_state = r_state;
    assign rnd_key   = {r_uk, r_lk};
    assign rnd_idx   = r_cnt;
    assign rnd_enc   = r_enc;

endmodule

`default_nettype wire

// File: tb/tb_des_mmio_engine.sv
// ============================================================================
// Module   : tb_des_mmio_engine
// Purpose  : Randomized bench for des_mmio_engine against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_mmio_engine;

    localparam int          ROUNDS = 16;
    localparam logic [31:0] BASE   = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        memwrite;
    logic [31:0] addr, wdata, rdata;
    logic        hit, busy, done, rnd_enc;
    logic [63:0] rnd_state, rnd_key, rnd_next;
    logic [3:0]  rnd_idx;
    logic        stub_mode;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Transaction-level model: an accepted start computes the whole answer at
    // once and a countdown decides when it becomes visible.
    logic [31:0] m_uk, m_lk, m_ud, m_ld, m_hi, m_lo;
    logic        m_enc, m_done;
    logic [63:0] m_res;
    int          m_left;

    des_mmio_engine #(.ROUNDS(ROUNDS), .BASE(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .memwrite(memwrite), .addr(addr),
        .wdata(wdata), .rdata(rdata), .hit(hit), .rnd_state(rnd_state),
        .rnd_key(rnd_key), .rnd_idx(rnd_idx), .rnd_enc(rnd_enc),
        .rnd_next(rnd_next), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] stub(input logic mode, input logic [63:0] s,
                                         input logic [63:0] k, input logic [3:0] i,
                                         input logic e);
        if (!mode) return s + 64'd1;
        return {s[62:0], s[63]} ^ (k + {59'd0, e, i});
    endfunction

    assign rnd_next = stub(stub_mode, rnd_state, rnd_key, rnd_idx, rnd_enc);

    function automatic logic [63:0] compute(input logic mode, input logic [63:0] st,
                                            input logic [63:0] key, input logic e);
        logic [63:0] s = st;
        for (int i = 0; i < ROUNDS; i++) s = stub(mode, s, key, 4'(i), e);
        return s;
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'h1F);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        logic [31:0] o;
        if (!m_hit(a)) return 32'h0;
        o = (a - BASE) >> 2;
        case (o)
            0: return m_uk;
            1: return m_lk;
            2: return m_ud;
            3: return m_ld;
            4: return {30'b0, m_enc, 1'b0};
            5: return {30'b0, m_done, (m_left > 0)};
            6: return m_hi;
            default: return m_lo;
        endcase
    endfunction

    task automatic model_reset();
        m_uk = 0; m_lk = 0; m_ud = 0; m_ld = 0; m_hi = 0; m_lo = 0;
        m_enc = 0; m_done = 0; m_res = 0; m_left = 0;
    endtask

    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                {m_hi, m_lo} = m_res;
                m_done = 1'b1;
            end
        end else if (we && m_hit(a)) begin
            case (o)
                0: m_uk = d;
                1: m_lk = d;
                2: m_ud = d;
                3: m_ld = d;
                4: if (d[0]) begin
                    m_enc  = d[1];
                    m_res  = compute(stub_mode, {m_ud, m_ld}, {m_uk, m_lk}, d[1]);
                    m_left = ROUNDS;
                    m_done = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hit",     64'(hit),     64'(m_hit(addr)));
            chk("rdata",   64'(rdata),   64'(m_rdata(addr)));
            chk("busy",    64'(busy),    64'(m_left > 0));
            chk("done",    64'(done),    64'(m_done));
            chk("rnd_key", rnd_key,      {m_uk, m_lk});
            chk("rnd_enc", 64'(rnd_enc), 64'(m_enc));
        end
    end

    // Inputs change 1 time unit after the active edge.
    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
        memwrite = we; addr = a; wdata = d;
        @(posedge clk);
        model_step(we, a, d);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        memwrite = 1'b0; addr = a;
        #1;
        v = rdata;
        @(posedge clk);
        model_step(1'b0, a, 32'h0);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            cyc(1'b0, 32'h0, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, ud_old;
        logic [63:0] e1, e2;
        int n;
        logic we;
        logic [31:0] a;

        reset_n = 1'b0; memwrite = 1'b0; addr = 32'h0; wdata = 32'h0; stub_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        rd(BASE + 32'h14, v); chk("reset_status", 64'(v), 64'h0);
        rd(BASE + 32'h00, v); chk("reset_uk",     64'(v), 64'h0);

        // Counting stub: 5 + 16 increments = 0x15.
        cyc(1'b1, BASE + 32'h08, 32'h0);
        cyc(1'b1, BASE + 32'h0C, 32'h5);
        cyc(1'b1, BASE + 32'h10, 32'h3);
        count_busy(n);
        chk("busy_len_stub", 64'(n), 64'd16);
        chk("model_lo_stub", 64'(m_lo), 64'h15);
        rd(BASE + 32'h1C, v); chk("out_lo_stub", 64'(v), 64'h15);
        rd(BASE + 32'h18, v); chk("out_hi_stub", 64'(v), 64'h0);
        rd(BASE + 32'h10, v); chk("ctrl_read",   64'(v), 64'h2);
        rd(BASE + 32'h14, v); chk("status_done", 64'(v), 64'h2);

        // Mixing stub; stores and restart attempts during RUN must be ignored.
        stub_mode = 1'b1;
        cyc(1'b1, BASE + 32'h00, 32'h1334_5779);
        cyc(1'b1, BASE + 32'h04, 32'h9BBC_DFF1);
        cyc(1'b1, BASE + 32'h08, 32'h0123_4567);
        cyc(1'b1, BASE + 32'h0C, 32'h89AB_CDEF);
        ud_old = 32'h0123_4567;
        e1 = compute(1'b1, 64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1, 1'b1);
        cyc(1'b1, BASE + 32'h10, 32'h3);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 3)      cyc(1'b1, BASE + 32'h08, 32'hFFFF_FFFF);
            else if (n == 4) cyc(1'b1, BASE + 32'h10, 32'h1);
            else if (n == 5) cyc(1'b1, BASE + 32'h00, 32'hAAAA_AAAA);
            else             cyc(1'b0, 32'h0, 32'h0);
        end
        chk("busy_len_run", 64'(n), 64'd16);
        cyc(1'b0, 32'h0, 32'h0);
        chk("no_restart", 64'(busy), 64'd0);
        rd(BASE + 32'h08, v); chk("ud_kept", 64'(v), 64'(ud_old));
        rd(BASE + 32'h18, v); chk("out_hi_run", 64'(v), 64'(e1[63:32]));
        rd(BASE + 32'h1C, v); chk("out_lo_run", 64'(v), 64'(e1[31:0]));

        // Address decode corners.
        cyc(1'b1, BASE + 32'h20, 32'hDEAD_BEEF);
        chk("hit_outside",   64'(hit),   64'd0);
        chk("rdata_outside", 64'(rdata), 64'd0);
        cyc(1'b1, BASE + 32'h18, 32'h1234_5678);
        rd(BASE + 32'h18, v); chk("out_hi_ro", 64'(v), 64'(e1[63:32]));
        rd(BASE + 32'h16, v); chk("status_alias", 64'(v), 64'h2);
        rd(BASE + 32'h00, v); chk("uk_after_decode", 64'(v), 64'h1334_5779);

        // Back-to-back: start on the first idle cycle after completion.
        cyc(1'b1, BASE + 32'h10, 32'h1);
        count_busy(n);
        e2 = compute(1'b1, 64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1, 1'b0);
        cyc(1'b1, BASE + 32'h10, 32'h3);
        chk("b2b_done_clr", 64'(done), 64'd0);
        chk("b2b_busy",     64'(busy), 64'd1);
        chk("b2b_prev_res", {m_hi, m_lo}, e2);
        count_busy(n);
        chk("b2b_len", 64'(n), 64'd16);
        chk("b2b_res", {m_hi, m_lo}, e1);

        // Asynchronous reset on the 7th busy cycle.
        cyc(1'b1, BASE + 32'h10, 32'h1);
        repeat (6) cyc(1'b0, 32'h0, 32'h0);
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        addr = BASE + 32'h14; #1; chk("arst_status", 64'(rdata), 64'd0);
        addr = BASE + 32'h18; #1; chk("arst_out_hi", 64'(rdata), 64'd0);
        addr = BASE + 32'h1C; #1; chk("arst_out_lo", 64'(rdata), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 600; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else                           a = BASE + $urandom_range(0, 39);
            cyc(we, a, $urandom);
        end
        count_busy(n);
        cyc(1'b0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
